// File: rtl/apb_rr_master_if.sv
// Requester-side handshake and APB master bus bundle for apb_rr_master.
// Member names keep the _i/_o direction as seen from the master.
interface apb_rr_master_if;
  localparam int unsigned NREQ = 2;
  localparam int unsigned DW   = 32;

  logic [NREQ-1:0]         req_valid_i;
  logic [NREQ-1:0]         req_ready_o;
  logic [NREQ-1:0]         req_write_i;
  logic [NREQ-1:0][DW-1:0] req_addr_i;
  logic [NREQ-1:0][DW-1:0] req_wdata_i;
  logic [NREQ-1:0]         rsp_valid_o;
  logic [DW-1:0]           rsp_rdata_o;
  logic                    rsp_err_o;

  logic                    psel_o;
  logic                    penable_o;
  logic                    pwrite_o;
  logic [DW-1:0]           paddr_o;
  logic [DW-1:0]           pwdata_o;
  logic [DW-1:0]           prdata_i;
  logic                    pready_i;

  modport master (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, prdata_i, pready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );

  modport slave (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, prdata_i, pready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );
endinterface

// File: rtl/apb_rr_master.sv
// Two-requester round-robin APB master with an ACCESS-phase timeout.
// One transfer in flight; completion is reported as a one-cycle pulse to the owner.
module apb_rr_master #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input logic              pclk,
  input logic              preset_n,
  apb_rr_master_if.master  bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            gnt_q, gnt_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [DW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [1:0]      rsp_valid_q, rsp_valid_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            gnt_c;
  logic [1:0]      ready_c;
  logic            timeout_c;
  logic            done_c;

  // Round-robin pick: under contention the requester not holding the pointer wins.
  always_comb begin
    gnt_c = 1'b0;
    unique case (bus.req_valid_i)
      2'b10:   gnt_c = 1'b1;
      2'b11:   gnt_c = ~ptr_q;
      default: gnt_c = 1'b0;
    endcase
    ready_c = '0;
    if (state_q == S_IDLE && preset_n) begin
      ready_c = bus.req_valid_i & (2'(1) << gnt_c);
    end
  end

  assign timeout_c = (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    rsp_valid_d = '0;
    cnt_d       = cnt_q;
    done_c      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (|ready_c) begin
          state_d  = S_SETUP;
          gnt_d    = gnt_c;
          ptr_d    = gnt_c;
          psel_d   = 1'b1;
          pwrite_d = bus.req_write_i[gnt_c];
          paddr_d  = bus.req_addr_i[gnt_c];
          pwdata_d = bus.req_wdata_i[gnt_c];
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      S_ACCESS: begin
        // A ready slave wins over a timeout firing in the same cycle.
        if (bus.pready_i) begin
          done_c  = 1'b1;
          rdata_d = bus.prdata_i;
          err_d   = 1'b0;
        end else if (timeout_c) begin
          done_c  = 1'b1;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (done_c) begin
      state_d     = S_IDLE;
      psel_d      = 1'b0;
      penable_d   = 1'b0;
      pwrite_d    = 1'b0;
      paddr_d     = '0;
      pwdata_d    = '0;
      rsp_valid_d = 2'(1) << gnt_q;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= 1'b1;
      gnt_q       <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.req_ready_o = ready_c;
  assign bus.psel_o      = psel_q;
  assign bus.penable_o   = penable_q;
  assign bus.pwrite_o    = pwrite_q;
  assign bus.paddr_o     = paddr_q;
  assign bus.pwdata_o    = pwdata_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;
endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: memory slave with programmable pready latency and a
// transaction-level reference model (grant pointer + sparse memory).
module tb_apb_rr_master;
  localparam int unsigned TO     = 6;
  localparam int          BUDGET = 100;

  logic pclk     = 1'b0;
  logic preset_n = 1'b0;

  apb_rr_master_if bus ();

  apb_rr_master #(.TIMEOUT_CYC(TO)) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (bus)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int passed = 0;

  // Slave: pready on the slv_lat-th ACCESS cycle (0 = never); prdata = stored word.
  int          slv_lat = 2;
  int          slv_acc = 0;
  logic [31:0] slv_mem [logic [31:0]];

  initial begin
    bus.pready_i = 1'b0;
    bus.prdata_i = '0;
    forever begin
      @(negedge pclk);
      if (!preset_n) begin
        slv_mem.delete();
        slv_acc      = 0;
        bus.pready_i = 1'b0;
        bus.prdata_i = '0;
      end else begin
        slv_acc      = (bus.psel_o && bus.penable_o) ? slv_acc + 1 : 0;
        bus.prdata_i = slv_mem.exists(bus.paddr_o) ? slv_mem[bus.paddr_o] : 32'h0;
        bus.pready_i = (slv_acc != 0) && (slv_acc == slv_lat);
        if (bus.pready_i && bus.pwrite_o) slv_mem[bus.paddr_o] = bus.pwdata_o;
      end
    end
  end

  // Reference model state
  bit          model_ptr = 1'b1;
  logic [31:0] model_mem [logic [31:0]];

  typedef struct {
    bit               done;
    bit               gnt;
    logic [1:0]       vmask;
    logic [1:0]       wr_v;
    logic [1:0][31:0] addr_v;
    logic [1:0][31:0] wdata_v;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    bit               wr;
    int               psel_n;
    int               pen_n;
    int               lat;
    logic [1:0]       rsp;
    logic [31:0]      rdata;
    logic             err;
    bit               stable_bad;
    bit               hold_bad;
    bit               idle_bad;
  } obs_t;

  typedef struct {
    bit          gnt;
    logic [1:0]  rsp;
    logic [31:0] rdata;
    logic        err;
    int          pen_n;
    int          lat;
  } exp_t;

  function automatic exp_t model_xfer(input obs_t o, input int lat_mode);
    exp_t        e;
    int          n;
    logic [31:0] a;
    logic [31:0] old;
    e.gnt     = (o.vmask == 2'b11) ? ~model_ptr : o.vmask[1];
    model_ptr = e.gnt;
    a         = o.addr_v[e.gnt];
    e.err     = (lat_mode == 0) || (lat_mode > int'(TO));
    n         = e.err ? int'(TO) : lat_mode;
    old       = model_mem.exists(a) ? model_mem[a] : 32'h0;
    e.rdata   = e.err ? 32'h0 : old;
    if (o.wr_v[e.gnt] && !e.err) model_mem[a] = o.wdata_v[e.gnt];
    e.rsp     = e.gnt ? 2'b10 : 2'b01;
    e.pen_n   = n;
    e.lat     = n + 2;
    return e;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'hA000 + 32'($urandom_range(0, 3) * 4);
  endfunction

  task automatic drive_req(input int r, input bit wr, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid_i[r] = 1'b1;
    bus.req_write_i[r] = wr;
    bus.req_addr_i[r]  = a;
    bus.req_wdata_i[r] = d;
  endtask

  task automatic apply_reset();
    preset_n        = 1'b0;
    bus.req_valid_i = '0;
    slv_lat         = 2;
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;
    model_mem.delete();
    model_ptr = 1'b1;
    #1;
  endtask

  // Follows one transfer from accept to the completion pulse (bounded).
  task automatic observe_xfer(input bit keep, output obs_t o);
    bit acc  = 1'b0;
    bit drop = 1'b0;
    int acc_c = 0;
    o = '{default: 0};
    for (int c = 0; c < BUDGET; c++) begin
      if (c > 0) begin
        @(negedge pclk);
        if (drop) begin
          drop = 1'b0;
          if (keep) bus.req_addr_i[o.gnt] = rand_addr();
          else      bus.req_valid_i[o.gnt] = 1'b0;
        end
      end
      #1;
      if (!acc) begin
        if (|(bus.req_ready_o & bus.req_valid_i)) begin
          acc      = 1'b1;
          acc_c    = c;
          drop     = 1'b1;
          o.gnt    = bus.req_ready_o[1];
          o.vmask  = bus.req_valid_i;
          o.wr_v   = bus.req_write_i;
          o.addr_v = bus.req_addr_i;
          o.wdata_v = bus.req_wdata_i;
          o.wr     = bus.req_write_i[o.gnt];
          o.addr   = bus.req_addr_i[o.gnt];
          o.wdata  = bus.req_wdata_i[o.gnt];
          if (bus.req_ready_o == 2'b11) o.hold_bad = 1'b1;
        end
      end else if (bus.rsp_valid_o != 2'b00) begin
        o.done  = 1'b1;
        o.lat   = c - acc_c;
        o.rsp   = bus.rsp_valid_o;
        o.rdata = bus.rsp_rdata_o;
        o.err   = bus.rsp_err_o;
        if (bus.psel_o || bus.penable_o || bus.pwrite_o || bus.paddr_o != 0 || bus.pwdata_o != 0)
          o.idle_bad = 1'b1;
        break;
      end else begin
        if (bus.req_ready_o != 2'b00) o.hold_bad = 1'b1;
        o.psel_n += int'(bus.psel_o);
        o.pen_n  += int'(bus.penable_o);
        if (!bus.psel_o || bus.paddr_o !== o.addr || bus.pwrite_o !== o.wr || bus.pwdata_o !== o.wdata)
          o.stable_bad = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    preset_n = 1'b0;
    drive_req(0, 1'b1, 32'hA000, 32'h1111_1111);
    drive_req(1, 1'b0, 32'hA004, 32'h2222_2222);
    repeat (2) @(negedge pclk);
    #1;
    checks++; if ({bus.psel_o, bus.penable_o, bus.pwrite_o} !== 3'b000) $display("FAIL rst_ctrl: got %b exp 000", {bus.psel_o, bus.penable_o, bus.pwrite_o}); else passed++;
    checks++; if ({bus.paddr_o, bus.pwdata_o} !== 64'h0) $display("FAIL rst_addr_data: got %h exp 0", {bus.paddr_o, bus.pwdata_o}); else passed++;
    checks++; if ({bus.rsp_rdata_o, bus.rsp_err_o} !== 33'h0) $display("FAIL rst_rsp: got %h exp 0", {bus.rsp_rdata_o, bus.rsp_err_o}); else passed++;
    checks++; if ({bus.rsp_valid_o, bus.req_ready_o} !== 4'b0000) $display("FAIL rst_valid_ready: got %b exp 0000", {bus.rsp_valid_o, bus.req_ready_o}); else passed++;
    preset_n = 1'b1;
    #1;
    checks++; if (bus.req_ready_o !== 2'b01) $display("FAIL rst_first_grant: got %b exp 01", bus.req_ready_o); else passed++;
    bus.req_valid_i = '0;
  endtask

  task automatic test_write_read();
    obs_t o;
    exp_t e;
    apply_reset();
    slv_lat = 2;
    drive_req(0, 1'b1, 32'hA000, 32'hDEAD_BEEF);
    observe_xfer(1'b0, o);
    e = model_xfer(o, 2);
    checks++; if (o.done !== 1'b1) $display("FAIL wr_done: got %b exp 1", o.done); else passed++;
    checks++; if (o.psel_n !== 3 || o.pen_n !== 2) $display("FAIL wr_phases: got psel %0d pen %0d exp 3 2", o.psel_n, o.pen_n); else passed++;
    checks++; if (o.rsp !== 2'b01 || o.err !== 1'b0) $display("FAIL wr_rsp: got %b err %b exp 01 err 0", o.rsp, o.err); else passed++;
    checks++; if (o.lat !== 4) $display("FAIL wr_latency: got %0d exp 4", o.lat); else passed++;
    checks++; if ({o.stable_bad, o.hold_bad, o.idle_bad} !== 3'b000) $display("FAIL wr_bus_rules: got %b exp 000", {o.stable_bad, o.hold_bad, o.idle_bad}); else passed++;
    drive_req(1, 1'b0, 32'hA000, 32'h0);
    observe_xfer(1'b0, o);
    e = model_xfer(o, 2);
    checks++; if (o.rsp !== 2'b10) $display("FAIL rd_rsp: got %b exp 10", o.rsp); else passed++;
    checks++; if (o.rdata !== 32'hDEAD_BEEF || e.rdata !== 32'hDEAD_BEEF) $display("FAIL rd_data: got %h exp %h", o.rdata, 32'hDEAD_BEEF); else passed++;
    bus.req_valid_i = '0;
  endtask

  task automatic test_arbitration();
    obs_t o;
    exp_t e;
    apply_reset();
    slv_lat = 1;
    drive_req(0, 1'b0, rand_addr(), 32'h0);
    drive_req(1, 1'b0, rand_addr(), 32'h0);
    for (int k = 0; k < 4; k++) begin
      observe_xfer(1'b1, o);
      e = model_xfer(o, 1);
      checks++; if (o.done !== 1'b1 || o.gnt !== e.gnt || o.gnt !== k[0]) $display("FAIL arb_grant%0d: got done %b gnt %b exp gnt %b", k, o.done, o.gnt, k[0]); else passed++;
      checks++; if (o.rsp !== e.rsp || o.lat !== e.lat || o.hold_bad) $display("FAIL arb_rsp%0d: got %b lat %0d exp %b lat %0d", k, o.rsp, o.lat, e.rsp, e.lat); else passed++;
    end
    bus.req_valid_i = '0;
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    int   lat;
    for (int k = 0; k < 16; k++) begin
      for (int r = 0; r < 2; r++) begin
        if (!bus.req_valid_i[r] && ($urandom_range(0, 1) == 1 || bus.req_valid_i == 2'b00))
          drive_req(r, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      end
      lat     = int'($urandom_range(1, 3));
      slv_lat = lat;
      observe_xfer(1'b0, o);
      e = model_xfer(o, lat);
      checks++; if (o.done !== 1'b1 || o.gnt !== e.gnt || o.rsp !== e.rsp) $display("FAIL rnd_grant%0d: got done %b gnt %b rsp %b exp gnt %b rsp %b", k, o.done, o.gnt, o.rsp, e.gnt, e.rsp); else passed++;
      checks++; if (o.rdata !== e.rdata || o.err !== e.err) $display("FAIL rnd_data%0d: got %h err %b exp %h err %b", k, o.rdata, o.err, e.rdata, e.err); else passed++;
      checks++; if (o.pen_n !== e.pen_n || o.lat !== e.lat || {o.stable_bad, o.hold_bad, o.idle_bad} != 3'b000) $display("FAIL rnd_timing%0d: got pen %0d lat %0d flags %b exp pen %0d lat %0d", k, o.pen_n, o.lat, {o.stable_bad, o.hold_bad, o.idle_bad}, e.pen_n, e.lat); else passed++;
    end
    bus.req_valid_i = '0;
  endtask

  task automatic test_timeout();
    obs_t o;
    exp_t e;
    slv_lat = 2;
    drive_req(0, 1'b1, 32'hA004, 32'h5A5A_5A5A);
    observe_xfer(1'b0, o);
    e = model_xfer(o, 2);
    slv_lat = 0;
    drive_req(0, 1'b0, 32'hA004, 32'h0);
    observe_xfer(1'b0, o);
    e = model_xfer(o, 0);
    checks++; if (o.done !== 1'b1 || o.err !== 1'b1 || o.rdata !== 32'h0) $display("FAIL to_err: got done %b err %b rdata %h exp 1 1 0", o.done, o.err, o.rdata); else passed++;
    checks++; if (o.pen_n !== int'(TO) || o.psel_n !== int'(TO) + 1 || o.rsp !== 2'b01) $display("FAIL to_cycles: got pen %0d psel %0d rsp %b exp %0d %0d 01", o.pen_n, o.psel_n, o.rsp, TO, TO + 1); else passed++;
    slv_lat = 2;
    drive_req(1, 1'b0, 32'hA004, 32'h0);
    observe_xfer(1'b0, o);
    e = model_xfer(o, 2);
    checks++; if (o.err !== 1'b0 || o.rdata !== 32'h5A5A_5A5A || o.rdata !== e.rdata) $display("FAIL to_recover: got err %b rdata %h exp 0 5a5a5a5a", o.err, o.rdata); else passed++;
    bus.req_valid_i = '0;
  endtask

  task automatic test_timeout_edge();
    obs_t o;
    exp_t e;
    slv_lat = int'(TO);
    drive_req(1, 1'b0, 32'hA004, 32'h0);
    observe_xfer(1'b0, o);
    e = model_xfer(o, int'(TO));
    checks++; if (o.err !== 1'b0 || o.rdata !== 32'h5A5A_5A5A || o.pen_n !== int'(TO)) $display("FAIL edge_ready: got err %b rdata %h pen %0d exp 0 5a5a5a5a %0d", o.err, o.rdata, o.pen_n, TO); else passed++;
    slv_lat = int'(TO) + 1;
    drive_req(0, 1'b0, 32'hA004, 32'h0);
    observe_xfer(1'b0, o);
    e = model_xfer(o, int'(TO) + 1);
    checks++; if (o.err !== e.err || o.err !== 1'b1 || o.rdata !== 32'h0) $display("FAIL edge_late: got err %b rdata %h exp 1 0", o.err, o.rdata); else passed++;
    bus.req_valid_i = '0;
  endtask

  task automatic test_reset_midxfer();
    obs_t o;
    exp_t e;
    int   pulses = 0;
    slv_lat = 0;
    drive_req(0, 1'b1, 32'hA000, 32'h1234_5678);
    for (int i = 0; i < 20 && !bus.penable_o; i++) begin
      @(negedge pclk);
      #1;
    end
    checks++; if (bus.penable_o !== 1'b1) $display("FAIL mid_reach_access: got %b exp 1", bus.penable_o); else passed++;
    bus.req_valid_i = '0;
    @(negedge pclk);
    #2;
    preset_n = 1'b0;
    #1;
    checks++; if ({bus.psel_o, bus.penable_o, bus.pwrite_o, bus.paddr_o, bus.pwdata_o} !== 67'h0) $display("FAIL mid_async_clear: got psel %b pen %b addr %h exp 0", bus.psel_o, bus.penable_o, bus.paddr_o); else passed++;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        preset_n = 1'b1;
        model_mem.delete();
        model_ptr = 1'b1;
      end
      @(negedge pclk);
      #1;
      if (bus.rsp_valid_o != 2'b00 || bus.psel_o) pulses++;
    end
    checks++; if (pulses !== 0) $display("FAIL mid_no_pulse: got %0d stray cycles exp 0", pulses); else passed++;
    slv_lat = 2;
    drive_req(1, 1'b0, 32'hA000, 32'h0);
    observe_xfer(1'b0, o);
    e = model_xfer(o, 2);
    checks++; if (o.done !== 1'b1 || o.rsp !== 2'b10 || o.rdata !== 32'h0 || o.rdata !== e.rdata) $display("FAIL mid_after_read: got done %b rsp %b rdata %h exp 1 10 0", o.done, o.rsp, o.rdata); else passed++;
    bus.req_valid_i = '0;
  endtask

  initial begin
    bus.req_valid_i = '0;
    bus.req_write_i = '0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    test_reset();
    test_write_read();
    test_arbitration();
    test_random();
    test_timeout();
    test_timeout_edge();
    test_reset_midxfer();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
